// File: rtl/id_regfile_sb_pkg.sv
// Shared CPU defines for the ID-stage register file and its scoreboard.
package id_regfile_sb_pkg;

    localparam int RF_NREG   = 32;
    localparam int RF_CNT_W  = 2;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = $clog2(RF_NREG);

    // One write-back port: data write and/or release of a pending claim.
    typedef struct packed {
        logic                 we;
        logic                 rel;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_port_t;

endpackage

// File: rtl/id_regfile_sb_if.sv
// Issue / write-back / read bundle between the ID stage and the register file.
interface id_regfile_sb_if
    import id_regfile_sb_pkg::*;
#(
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);
    logic                             flush;
    logic [NUM_WR-1:0]                iss_valid;
    logic [NUM_WR-1:0][ADDR_W-1:0]    iss_dst;
    logic                             iss_ready;
    logic [NUM_WR-1:0]                wb_we;
    logic [NUM_WR-1:0]                wb_rel;
    logic [NUM_WR-1:0][ADDR_W-1:0]    wb_addr;
    logic [NUM_WR-1:0][DATA_W-1:0]    wb_data;
    logic [NUM_RD-1:0]                rd_en;
    logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]                rd_busy;
    logic                             stall;
    logic                             err_underflow;

    modport master (
        output flush, iss_valid, iss_dst, wb_we, wb_rel, wb_addr, wb_data, rd_en, rd_addr,
        input  iss_ready, rd_data, rd_busy, stall, err_underflow
    );

    modport slave (
        input  flush, iss_valid, iss_dst, wb_we, wb_rel, wb_addr, wb_data, rd_en, rd_addr,
        output iss_ready, rd_data, rd_busy, stall, err_underflow
    );
endinterface

// File: rtl/id_regfile_sb_ctr.sv
// Per-register pending-writer counter: net claim/release delta, overflow
// look-ahead for issue gating, clamp at zero with underflow flag.
module rf_pending_ctr #(
    parameter int NUM_WR = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              iss_ok,
    input  logic [NUM_WR-1:0] claim,
    input  logic [NUM_WR-1:0] rel,
    output logic              ovf,
    output logic              pend_nz,
    output logic              uf
);
    // Signed headroom for cnt + all claims - all releases.
    localparam int SW   = CNT_W + $clog2(NUM_WR + 1) + 2;
    localparam int MAXV = (1 << CNT_W) - 1;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [SW-1:0] cur, nclaim, nrel, sum_all, eff, after_rel;

    // Count same-cycle events and derive next value, overflow and busy.
    always_comb begin
        nclaim = '0;
        nrel   = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            nclaim = nclaim + SW'(claim[j]);
            nrel   = nrel + SW'(rel[j]);
        end
        cur       = $signed({{(SW - CNT_W){1'b0}}, cnt_q});
        // Overflow check assumes the claims go through, so it must not depend on iss_ok.
        sum_all   = cur + nclaim - nrel;
        ovf       = sum_all > $signed(SW'(MAXV));
        eff       = cur + (iss_ok ? nclaim : '0) - nrel;
        uf        = eff < 0;
        after_rel = cur - nrel;
        pend_nz   = after_rel > 0;
        if (flush || uf) cnt_d = '0;
        else             cnt_d = eff[CNT_W-1:0];
    end

    // Counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage register file with write-back forwarding and a per-register
// pending-writer scoreboard that produces busy/stall and issue backpressure.
module id_regfile_sb
    import id_regfile_sb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = RF_NREG,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic           clk,
    input  logic           resetn,
    id_regfile_sb_if.slave bus
);
    localparam int ADDR_W = $clog2(NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              ovf     [NREG];
    logic              pend_nz [NREG];
    logic              uf      [NREG];
    logic              iss_ready;
    logic              err_q, err_d;

    // Storage update: later write ports override earlier ones; r0 stays zero.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREG; r++)
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wb_we[j] && bus.wb_addr[j] == ADDR_W'(r)) regs_d[r] = bus.wb_data[j];
        regs_d[0] = '0;
    end

    // Register storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        else         regs_q <= regs_d;
    end

    // r0 has no counter: it never claims and is never busy.
    assign ovf[0]     = 1'b0;
    assign pend_nz[0] = 1'b0;
    assign uf[0]      = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_ctr
        logic [NUM_WR-1:0] claim_hit, rel_hit;

        // Decode which issue slots / write ports target this register.
        always_comb begin
            claim_hit = '0;
            rel_hit   = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                claim_hit[j] = bus.iss_valid[j] && bus.iss_dst[j] == ADDR_W'(r);
                rel_hit[j]   = bus.wb_rel[j] && bus.wb_addr[j] == ADDR_W'(r);
            end
        end

        rf_pending_ctr #(.NUM_WR(NUM_WR), .CNT_W(CNT_W)) u_ctr (
            .clk     (clk),
            .resetn  (resetn),
            .flush   (bus.flush),
            .iss_ok  (iss_ready),
            .claim   (claim_hit),
            .rel     (rel_hit),
            .ovf     (ovf[r]),
            .pend_nz (pend_nz[r]),
            .uf      (uf[r])
        );
    end

    // Issue is all-or-nothing: any counter that would overflow blocks every slot.
    always_comb begin
        iss_ready = 1'b1;
        for (int r = 0; r < NREG; r++) if (ovf[r]) iss_ready = 1'b0;
    end
    assign bus.iss_ready = iss_ready;

    // Read ports: forward from the highest matching write port, else storage.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        bus.stall   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_addr[i] != '0 && int'(bus.rd_addr[i]) < NREG) begin
                bus.rd_data[i] = regs_q[bus.rd_addr[i]];
                for (int j = 0; j < NUM_WR; j++)
                    if (bus.wb_we[j] && bus.wb_addr[j] == bus.rd_addr[i]) bus.rd_data[i] = bus.wb_data[j];
                bus.rd_busy[i] = pend_nz[bus.rd_addr[i]];
            end
            if (bus.rd_en[i] && bus.rd_busy[i]) bus.stall = 1'b1;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) if (uf[r]) err_d = 1'b1;
    end

    // Error flag state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= err_d;
    end
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_id_regfile_sb.sv
// Cycle-table bench for id_regfile_sb: each record is one ID cycle of
// stimulus plus the combinational outputs expected in that cycle.
module tb_id_regfile_sb;
    import id_regfile_sb_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_regfile_sb_if #(.NUM_RD(4), .NUM_WR(2), .ADDR_W(5), .DATA_W(32)) bus ();

    id_regfile_sb dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [1:0]  iss_v;
        logic [4:0]  d0, d1;
        rf_wr_port_t wb0, wb1;
        logic [3:0]  rd_en;
        logic [4:0]  ra0, ra1;
        logic        flush;
        logic        e_ready, e_stall;
        logic [3:0]  e_busy;
        logic [31:0] e_rd0, e_rd1;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic [1:0] iv, logic [4:0] d0, logic [4:0] d1,
                                logic [1:0] we, logic [1:0] rel, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] w0, logic [31:0] w1,
                                logic [3:0] re, logic [4:0] r0, logic [4:0] r1, logic fl,
                                logic er, logic es, logic [3:0] eb,
                                logic [31:0] e0, logic [31:0] e1, logic ee);
        vec_t v;
        v.iss_v = iv; v.d0 = d0; v.d1 = d1;
        v.wb0 = '{we: we[0], rel: rel[0], addr: a0, data: w0};
        v.wb1 = '{we: we[1], rel: rel[1], addr: a1, data: w1};
        v.rd_en = re; v.ra0 = r0; v.ra1 = r1; v.flush = fl;
        v.e_ready = er; v.e_stall = es; v.e_busy = eb;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.iss_valid  = v.iss_v;
        bus.iss_dst[0] = v.d0;
        bus.iss_dst[1] = v.d1;
        bus.wb_we      = {v.wb1.we, v.wb0.we};
        bus.wb_rel     = {v.wb1.rel, v.wb0.rel};
        bus.wb_addr[0] = v.wb0.addr;
        bus.wb_addr[1] = v.wb1.addr;
        bus.wb_data[0] = v.wb0.data;
        bus.wb_data[1] = v.wb1.data;
        bus.rd_en      = v.rd_en;
        bus.rd_addr[0] = v.ra0;
        bus.rd_addr[1] = v.ra1;
        bus.rd_addr[2] = '0;
        bus.rd_addr[3] = '0;
        bus.flush      = v.flush;
    endtask

    // One cycle: drive after the edge, check outputs at the falling edge.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, ".iss_ready"}, 32'(bus.iss_ready), 32'(e.e_ready));
        chk({tag, ".stall"},     32'(bus.stall),     32'(e.e_stall));
        chk({tag, ".rd_busy"},   32'(bus.rd_busy),   32'(e.e_busy));
        chk({tag, ".rd_data0"},  bus.rd_data[0],     e.e_rd0);
        chk({tag, ".rd_data1"},  bus.rd_data[1],     e.e_rd1);
        chk({tag, ".err"},       32'(bus.err_underflow), 32'(e.e_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          iv d0 d1  we rel a0 a1  w0            w1        re ra0 ra1 fl  rdy stl busy rd0           rd1       err
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        1, 5,  0,  0,  1, 0, 0, 0,            0,        0)); // t0 idle read r5
        tbl.push_back(mk(1, 5, 0,  0, 0,  0, 0,  0,            0,        0, 5,  0,  0,  1, 0, 0, 0,            0,        0)); // t1 claim r5
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        1, 5,  0,  0,  1, 1, 1, 0,            0,        0)); // t2 r5 busy
        tbl.push_back(mk(0, 0, 0,  1, 1,  5, 0,  32'hDEADBEEF, 0,        1, 5,  0,  0,  1, 0, 0, 32'hDEADBEEF, 0,        0)); // t3 fwd+release
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        1, 5,  0,  0,  1, 0, 0, 32'hDEADBEEF, 0,        0)); // t4 stored
        tbl.push_back(mk(3, 7, 7,  0, 0,  0, 0,  0,            0,        0, 7,  0,  0,  1, 0, 0, 0,            0,        0)); // t5 r7 +2
        tbl.push_back(mk(1, 7, 0,  0, 0,  0, 0,  0,            0,        0, 7,  0,  0,  1, 0, 1, 0,            0,        0)); // t6 r7 +1 -> 3
        tbl.push_back(mk(3, 7, 12, 1, 0,  11,0,  32'h77,       0,        0, 7,  12, 0,  0, 0, 1, 0,            0,        0)); // t7 overflow blocks
        tbl.push_back(mk(1, 7, 0,  0, 2,  0, 7,  0,            0,        0, 7,  0,  0,  1, 0, 1, 0,            0,        0)); // t8 claim+release
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        3, 11, 12, 0,  1, 0, 0, 32'h77,       0,        0)); // t9 write landed, r12 not claimed
        tbl.push_back(mk(0, 0, 0,  0, 1,  7, 0,  0,            0,        1, 7,  0,  0,  1, 1, 1, 0,            0,        0)); // t10 r7 3->2
        tbl.push_back(mk(0, 0, 0,  0, 1,  7, 0,  0,            0,        1, 7,  0,  0,  1, 1, 1, 0,            0,        0)); // t11 r7 2->1
        tbl.push_back(mk(0, 0, 0,  0, 1,  7, 0,  0,            0,        1, 7,  0,  0,  1, 0, 0, 0,            0,        0)); // t12 r7 1->0
        tbl.push_back(mk(0, 0, 0,  3, 0,  9, 9,  32'h11,       32'h22,   3, 9,  9,  0,  1, 0, 0, 32'h22,       32'h22,   0)); // t13 dual write
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        1, 9,  0,  0,  1, 0, 0, 32'h22,       0,        0)); // t14 port1 won
        tbl.push_back(mk(0, 0, 0,  0, 1,  3, 0,  0,            0,        1, 3,  0,  0,  1, 0, 0, 0,            0,        0)); // t15 release at 0
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        1, 3,  0,  0,  1, 0, 0, 0,            0,        1)); // t16 err sticky
        tbl.push_back(mk(2, 0, 3,  0, 0,  0, 0,  0,            0,        0, 3,  0,  0,  1, 0, 0, 0,            0,        1)); // t17 claim r3
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        1, 3,  0,  0,  1, 1, 1, 0,            0,        1)); // t18 r3 was clamped
        tbl.push_back(mk(0, 0, 0,  0, 2,  0, 3,  0,            0,        1, 3,  0,  0,  1, 0, 0, 0,            0,        1)); // t19 cancelled writer
        tbl.push_back(mk(3, 4, 6,  0, 0,  0, 0,  0,            0,        0, 0,  0,  0,  1, 0, 0, 0,            0,        1)); // t20 claim r4,r6
        tbl.push_back(mk(1, 8, 0,  1, 0,  0, 0,  5,            0,        3, 4,  6,  1,  1, 1, 3, 0,            0,        1)); // t21 flush + claim r8
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,            0,        3, 4,  6,  0,  1, 0, 0, 0,            0,        1)); // t22 flushed
        tbl.push_back(mk(0, 0, 0,  1, 0,  0, 0,  5,            0,        1, 0,  8,  0,  1, 0, 0, 0,            0,        1)); // t23 r0 zero, r8 idle

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.rd_addr[0] = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.iss_ready", 32'(bus.iss_ready), 32'd1);
        chk("rst.rd_busy",   32'(bus.rd_busy),   32'd0);
        chk("rst.stall",     32'(bus.stall),     32'd0);
        chk("rst.rd_data0",  bus.rd_data[0],     32'd0);
        chk("rst.err",       32'(bus.err_underflow), 32'd0);
        resetn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) step($sformatf("t%0d", k), tbl[k]);

        // Reset asserted mid-operation discards pending claims and storage.
        step("h0", mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        step("h1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 1, 0, 0, 1));
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst.rd_busy", 32'(bus.rd_busy), 32'd0);
        chk("mrst.stall",   32'(bus.stall),   32'd0);
        chk("mrst.err",     32'(bus.err_underflow), 32'd0);
        bus.rd_addr[1] = 5'd9;
        #1;
        chk("mrst.rd_data1", bus.rd_data[1], 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step("h2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5, 0, 1, 0, 0, 0, 0, 0));

        chk("sb.empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
